// File: rtl/cpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_seq_pkg
// Description : Shared state encodings and halt-cause codes for cpu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_seq_pkg;

   localparam int IW_DEFAULT = 16;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_EXEC1  = 3'd2;
   localparam logic [2:0] ST_EXEC2  = 3'd3;
   localparam logic [2:0] ST_EXEC3  = 3'd4;
   localparam logic [2:0] ST_HALTED = 3'd5;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_EXT  = 2'b01;
   localparam logic [1:0] CAUSE_BP   = 2'b10;
   localparam logic [1:0] CAUSE_STEP = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle CPU phase sequencer with IR, run control,
//               breakpoint/step/halt handling and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int AW    = 8,
   parameter int IW    = IW_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             resume,
   input  logic             step,
   input  logic             halt_req,
   input  logic             bp_en,
   input  logic [AW-1:0]    bp_addr,
   input  logic [AW-1:0]    pc,
   input  logic [IW-1:0]    rom_q,
   input  logic             extra,
   input  logic             extra2,
   output logic [IW-1:0]    ir,
   output logic             fetch,
   output logic             exec1,
   output logic             exec2,
   output logic             exec3,
   output logic             running,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instr_count
);

   state_t           r_state;
   logic [IW-1:0]    r_ir;
   logic [1:0]       r_cause;
   logic [CNT_W-1:0] r_count;
   logic             r_halt_pend;
   logic             r_step_pend;
   logic             r_bp_skip;

   logic w_bp_hit;
   logic w_boundary;
   logic w_halt_now;

   // bp_skip lets the instruction at a just-reported breakpoint PC execute.
   assign w_bp_hit   = bp_en && (pc == bp_addr) && !r_bp_skip;
   assign w_boundary = ((r_state == ST_EXEC1) && !extra)  ||
                       ((r_state == ST_EXEC2) && !extra2) ||
                        (r_state == ST_EXEC3);
   assign w_halt_now = r_halt_pend || halt_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ir        <= '0;
         r_cause     <= CAUSE_NONE;
         r_count     <= '0;
         r_halt_pend <= 1'b0;
         r_step_pend <= 1'b0;
         r_bp_skip   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start)
                  r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (w_bp_hit) begin
                  r_state     <= ST_HALTED;
                  r_cause     <= CAUSE_BP;
                  r_halt_pend <= 1'b0;
                  r_step_pend <= 1'b0;
               end else begin
                  r_ir      <= rom_q;
                  r_bp_skip <= 1'b0;
                  r_state   <= ST_EXEC1;
                  if (halt_req)
                     r_halt_pend <= 1'b1;
               end
            end
            ST_EXEC1, ST_EXEC2, ST_EXEC3: begin
               if (w_boundary) begin
                  r_count <= r_count + 1'b1;
                  if (w_halt_now) begin
                     r_state     <= ST_HALTED;
                     r_cause     <= CAUSE_EXT;
                     r_halt_pend <= 1'b0;
                     r_step_pend <= 1'b0;
                  end else if (r_step_pend) begin
                     r_state     <= ST_HALTED;
                     r_cause     <= CAUSE_STEP;
                     r_halt_pend <= 1'b0;
                     r_step_pend <= 1'b0;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end else begin
                  r_state <= (r_state == ST_EXEC1) ? ST_EXEC2 : ST_EXEC3;
                  if (halt_req)
                     r_halt_pend <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  r_state   <= ST_FETCH;
                  r_bp_skip <= 1'b1;
                  r_cause   <= CAUSE_NONE;
               end else if (step) begin
                  r_state     <= ST_FETCH;
                  r_bp_skip   <= 1'b1;
                  r_step_pend <= 1'b1;
                  r_cause     <= CAUSE_NONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ir          = r_ir;
   assign fetch       = (r_state == ST_FETCH);
   assign exec1       = (r_state == ST_EXEC1);
   assign exec2       = (r_state == ST_EXEC2);
   assign exec3       = (r_state == ST_EXEC3);
   assign running     = fetch || exec1 || exec2 || exec3;
   assign halted      = (r_state == ST_HALTED);
   assign halt_cause  = r_cause;
   assign instr_count = r_count;

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Phase sequencer and run-control unit for the multi-cycle CPU core.
- Generates the one-hot fetch/exec1/exec2/exec3 phase strobes consumed by the instruction decoder, and latches the fetched instruction into the instruction register (IR).
- Extends an instruction into EXEC2/EXEC3 from the decoder's extra/extra2 feedback.
- Provides start, halt, single-step and PC-breakpoint control, plus a retired-instruction counter.

Parameters:
- AW, 8, PC/ROM address width.
- IW, 16, instruction width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE.
- resume  in  1  pulse; leaves HALTED and free-runs.
- step  in  1  pulse; from HALTED, executes exactly one instruction.
- halt_req  in  1  pulse; requests a halt at the next instruction boundary.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  AW  breakpoint PC.
- pc  in  AW  current PC, stable during FETCH.
- rom_q  in  IW  ROM data at pc, valid during FETCH.
- extra  in  1  decoder: instruction needs EXEC2.
- extra2  in  1  decoder: instruction needs EXEC3.
- ir  out  IW  instruction register, feeds decoder.
- fetch, exec1, exec2, exec3  out  1 each  one-hot phase strobes.
- running  out  1  state is FETCH or an EXEC state.
- halted  out  1  state is HALTED.
- halt_cause  out  2  00 none, 01 external, 10 breakpoint, 11 step.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high on clk.
  - Reset values: state IDLE, ir=0, all phase strobes 0, running=0, halted=0, halt_cause=00, instr_count=0, halt_pend=0, step_pend=0, bp_skip=0.
  - Reset mid-instruction aborts immediately; no phase strobe is asserted in the cycle after reset.
- States: IDLE, FETCH, EXEC1, EXEC2, EXEC3, HALTED. Phase strobes are registered-state decodes, at most one high. In IDLE/HALTED all strobes are 0, so no downstream write or PC load can occur.
- IDLE:
  - start=1 -> FETCH.
  - Other inputs ignored; start outside IDLE is ignored.
- FETCH:
  - Breakpoint: if bp_en=1, pc==bp_addr and bp_skip=0 -> HALTED with cause 10. IR is not loaded and nothing retires.
  - Otherwise: ir<=rom_q, bp_skip<=0, -> EXEC1.
- EXEC1: extra=1 -> EXEC2, else boundary.
- EXEC2: extra2=1 -> EXEC3, else boundary.
- EXEC3: always boundary.
- Latency per instruction:
  - 2 cycles when extra=0.
  - 3 cycles when extra=1, extra2=0.
  - 4 cycles when extra=1, extra2=1.
  - extra2 is ignored when extra=0.
- Boundary (the last EXEC cycle of an instruction):
  - instr_count increments and wraps modulo 2^CNT_W.
  - Next state, in priority order:
    1. halt_pend, or halt_req in this cycle -> HALTED, cause 01.
    2. step_pend -> HALTED, cause 11.
    3. Otherwise -> FETCH.
  - halt_pend and step_pend clear when HALTED is entered.
- halt_req:
  - Latched into halt_pend in FETCH or any EXEC state.
  - Ignored in IDLE and HALTED.
  - Never aborts an instruction in progress.
- HALTED:
  - resume=1 -> FETCH, bp_skip<=1, cause<=00.
  - Otherwise step=1 -> FETCH, bp_skip<=1, step_pend<=1, cause<=00. resume wins if both are asserted.
  - bp_skip lets execution continue from the breakpoint PC.
- step while running is ignored.
- halt_cause holds its value until leaving HALTED.
- running and halted are direct state decodes with no added latency.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum (IDLE, FETCH, EXEC1, EXEC2, EXEC3, HALTED);
  - halt_cause constants CAUSE_NONE/EXT/BP/STEP;
  - IW default.
- Single module; no sub-module is warranted. The counter and breakpoint compare stay inline.

Test Plan:
1. Reset, then start. ROM program: word0 with extra=0, word1 with extra=1/extra2=0, word2 with extra=1/extra2=1. Required: phase sequence F,E1,F,E1,E2,F,E1,E2,E3; ir equals each ROM word from the cycle after its FETCH; instr_count=3 after 9 cycles.
2. halt_req pulse during EXEC1 of a 4-cycle instruction. Required: E2 and E3 complete, then halted=1, halt_cause=01, instr_count incremented exactly once; no strobes while halted.
3. bp_en=1, bp_addr=0x05; PC reaches 0x05. Required: HALTED after that FETCH with cause 10, ir unchanged, count not incremented. Then resume: that FETCH proceeds without re-halting and ir=rom_q at 0x05.
4. From HALTED, step pulse. Required: exactly one instruction executes, return to HALTED with cause 11, count +1. Simultaneous step+resume: free-run with no return to HALTED.
5. Assert reset during EXEC2. Required: next cycle state IDLE, all strobes 0, ir=0, count=0; start restarts cleanly from FETCH.
6. CNT_W=4, 17 single-cycle-extra instructions. Required: instr_count wraps 15->0 and reads 1 at the end.
